// File: rtl/hazard_pkg.sv
// Shared hazard-unit definitions: Tuse/Tnew class constants, MDU latency
// defaults and the forward-select encoding used by stall_hazard_unit.
package hazard_pkg;

  // Tuse/Tnew field width
  localparam int unsigned T_W = 4;

  // Operand not read by the D instruction: never stalls
  localparam logic [T_W-1:0] TUSE_NONE = '1;

  // Tuse classes (cycles from D until the operand is consumed)
  localparam logic [T_W-1:0] TUSE_BRANCH = T_W'(0);
  localparam logic [T_W-1:0] TUSE_ALU    = T_W'(1);
  localparam logic [T_W-1:0] TUSE_STORE  = T_W'(2);
  localparam logic [T_W-1:0] TUSE_MDU    = T_W'(1);

  // Tnew classes as seen in E (cycles until the result exists)
  localparam logic [T_W-1:0] TNEW_ALU_E  = T_W'(1);
  localparam logic [T_W-1:0] TNEW_LOAD_E = T_W'(2);
  localparam logic [T_W-1:0] TNEW_MDU_E  = T_W'(1);

  // MDU latency defaults
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Forward-select encoding: 0 = register file, k+1 = stage k
  localparam int unsigned FWD_W = 3;
  localparam logic [FWD_W-1:0] FWD_RF = FWD_W'(0);
  localparam logic [FWD_W-1:0] FWD_E  = FWD_W'(1);
  localparam logic [FWD_W-1:0] FWD_M  = FWD_W'(2);
  localparam logic [FWD_W-1:0] FWD_W_STAGE = FWD_W'(3);

  // MDU tracker states
  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // Forward code for producer stage k
  function automatic logic [FWD_W-1:0] fwd_from_stage(input int unsigned k);
    return FWD_W'(k + 1);
  endfunction

endpackage

// File: rtl/mdu_busy_tracker.sv
// Tracks the multi-cycle MDU: loads the mult/div latency on a start seen
// while idle, counts down to zero, and flags busy while the count is non-zero.
// Ports: clk, rst_n (async active-low), start, is_div (1 = div), busy.
module mdu_busy_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = hazard_pkg::MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = hazard_pkg::DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

  // Counter is sized from DIV_CYCLES; a longer mult latency would not fit
  if (MULT_CYCLES >= (2 ** CW)) begin : g_bad_mult
    $error("mdu_busy_tracker: MULT_CYCLES does not fit the counter");
  end

  mdu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // State and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d == MDU_BUSY);
    end
  end

  // Load on start from idle, otherwise count down; starts while busy are dropped
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = MDU_IDLE;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A second start while busy indicates a decode/issue bug upstream
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(start && busy))
    else $error("mdu_busy_tracker: MDU start while busy ignored");

endmodule

// File: rtl/stall_hazard_unit.sv
// D-stage hazard unit: per-operand Tuse/Tnew stall detection and forward
// selection across NUM_STAGES producer stages (0 = E, 1 = M, 2 = W, ...),
// plus MDU-class stalling driven by mdu_busy_tracker.
// Optional feature macro: STALL_PERF_CNT_EN adds the o_StallCnt counter.
// Ports: i_D_Rs/i_D_Rt + Tuse (D sources), i_D_IsMdu, i_WAddr/i_Tnew
// (packed per stage), i_E_MduStart/i_E_MduIsDiv, i_StatClr; outputs
// o_Stall, o_FwdRs, o_FwdRt (combinational), o_MduBusy, o_StallCnt.
module stall_hazard_unit #(
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned T_W         = hazard_pkg::T_W,
  parameter int unsigned MULT_CYCLES = hazard_pkg::MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = hazard_pkg::DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4:0]              i_D_Rs,
  input  logic [4:0]              i_D_Rt,
  input  logic [T_W-1:0]          i_D_TuseRs,
  input  logic [T_W-1:0]          i_D_TuseRt,
  input  logic                    i_D_IsMdu,
  input  logic [NUM_STAGES*5-1:0] i_WAddr,
  input  logic [NUM_STAGES*T_W-1:0] i_Tnew,
  input  logic                    i_E_MduStart,
  input  logic                    i_E_MduIsDiv,
  input  logic                    i_StatClr,
  output logic                    o_Stall,
  output logic [2:0]              o_FwdRs,
  output logic [2:0]              o_FwdRt,
  output logic                    o_MduBusy
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]        o_StallCnt
`endif
);

  import hazard_pkg::*;

  if (NUM_STAGES < 1 || NUM_STAGES > 4) begin : g_bad_stages
    $error("stall_hazard_unit: NUM_STAGES must be 1..4");
  end

  logic [NUM_STAGES-1:0] rs_match, rt_match;
  logic [NUM_STAGES-1:0] rs_stall, rt_stall;
  logic [NUM_STAGES-1:0] tnew_zero;
  logic                  mdu_stall;

  // Per-stage destination compare and Tuse/Tnew check
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [4:0]     waddr;
    logic [T_W-1:0] tnew;
    assign waddr        = i_WAddr[5*k +: 5];
    assign tnew         = i_Tnew[T_W*k +: T_W];
    assign rs_match[k]  = (i_D_Rs == waddr) && (waddr != 5'd0);
    assign rt_match[k]  = (i_D_Rt == waddr) && (waddr != 5'd0);
    assign rs_stall[k]  = rs_match[k] && (i_D_TuseRs < tnew);
    assign rt_stall[k]  = rt_match[k] && (i_D_TuseRt < tnew);
    assign tnew_zero[k] = (tnew == '0);
  end

  // Youngest matching stage decides; a not-yet-ready match hides older copies
  always_comb begin
    logic rs_found, rt_found;
    o_FwdRs  = FWD_RF;
    o_FwdRt  = FWD_RF;
    rs_found = 1'b0;
    rt_found = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (!rs_found && rs_match[k]) begin
        rs_found = 1'b1;
        if (tnew_zero[k]) o_FwdRs = fwd_from_stage(k);
      end
      if (!rt_found && rt_match[k]) begin
        rt_found = 1'b1;
        if (tnew_zero[k]) o_FwdRt = fwd_from_stage(k);
      end
    end
  end

  mdu_busy_tracker #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_busy (
    .clk   (clk),
    .rst_n (rst_n),
    .start (i_E_MduStart),
    .is_div(i_E_MduIsDiv),
    .busy  (o_MduBusy)
  );

  // In the start cycle the tracker is not yet busy, so the start itself stalls
  assign mdu_stall = i_D_IsMdu && (o_MduBusy || i_E_MduStart);
  assign o_Stall   = (|rs_stall) || (|rt_stall) || mdu_stall;

`ifdef STALL_PERF_CNT_EN
  // Saturating stall-cycle counter; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_StallCnt <= '0;
    end else if (i_StatClr) begin
      o_StallCnt <= '0;
    end else if (o_Stall && (o_StallCnt != '1)) begin
      o_StallCnt <= o_StallCnt + CNT_W'(1);
    end
  end
`else
  logic unused_stat_clr;
  localparam int unsigned unused_cnt_w = CNT_W;
  assign unused_stat_clr = i_StatClr;
`endif

endmodule

// File: tb/tb_stall_hazard_unit.sv
module tb_stall_hazard_unit;

  localparam int unsigned NS    = 3;
  localparam int unsigned TW    = 4;
  localparam int unsigned MULTC = 5;
  localparam int unsigned DIVC  = 10;
  localparam int unsigned CW    = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      d_rs, d_rt;
  logic [TW-1:0]   tuse_rs, tuse_rt;
  logic            d_is_mdu;
  logic [4:0]      waddr_a [NS];
  logic [TW-1:0]   tnew_a  [NS];
  logic [NS*5-1:0] waddr_bus;
  logic [NS*TW-1:0] tnew_bus;
  logic            mdu_start, mdu_is_div, stat_clr;
  logic            stall, mdu_busy;
  logic [2:0]      fwd_rs, fwd_rt;
  logic [CW-1:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state: edges seen, edge at which the MDU goes idle, stall count
  int            cyc = 0;
  int            busy_until = 0;
  logic [CW-1:0] cnt_model = '0;

  always #5 clk = ~clk;

  always_comb begin
    waddr_bus = '0;
    tnew_bus  = '0;
    for (int k = 0; k < NS; k++) begin
      waddr_bus[5*k +: 5]   = waddr_a[k];
      tnew_bus[TW*k +: TW]  = tnew_a[k];
    end
  end

  stall_hazard_unit #(
    .NUM_STAGES (NS),
    .T_W        (TW),
    .MULT_CYCLES(MULTC),
    .DIV_CYCLES (DIVC),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_D_Rs      (d_rs),
    .i_D_Rt      (d_rt),
    .i_D_TuseRs  (tuse_rs),
    .i_D_TuseRt  (tuse_rt),
    .i_D_IsMdu   (d_is_mdu),
    .i_WAddr     (waddr_bus),
    .i_Tnew      (tnew_bus),
    .i_E_MduStart(mdu_start),
    .i_E_MduIsDiv(mdu_is_div),
    .i_StatClr   (stat_clr),
    .o_Stall     (stall),
    .o_FwdRs     (fwd_rs),
    .o_FwdRt     (fwd_rt),
    .o_MduBusy   (mdu_busy)
`ifdef STALL_PERF_CNT_EN
    ,
    .o_StallCnt  (stall_cnt)
`endif
  );

`ifndef STALL_PERF_CNT_EN
  assign stall_cnt = '0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  function automatic bit model_busy();
    return cyc < busy_until;
  endfunction

  // Operand rule: stall if any matching producer is late; youngest match decides forwarding
  function automatic void model_operand(input logic [4:0] src, input logic [TW-1:0] tuse,
                                        output bit st, output logic [2:0] fwd);
    bit decided = 0;
    st  = 0;
    fwd = 3'd0;
    for (int k = 0; k < NS; k++) begin
      if (src != 5'd0 && waddr_a[k] == src) begin
        if (tuse < tnew_a[k]) st = 1;
        if (!decided) begin
          decided = 1;
          fwd = (tnew_a[k] == 0) ? 3'(k + 1) : 3'd0;
        end
      end
    end
  endfunction

  function automatic bit model_stall();
    bit s_rs, s_rt;
    logic [2:0] f;
    model_operand(d_rs, tuse_rs, s_rs, f);
    model_operand(d_rt, tuse_rt, s_rt, f);
    return s_rs || s_rt || (d_is_mdu && (model_busy() || mdu_start));
  endfunction

  task automatic check_comb(input string tag);
    bit s_rs, s_rt;
    logic [2:0] f_rs, f_rt;
    #1;
    model_operand(d_rs, tuse_rs, s_rs, f_rs);
    model_operand(d_rt, tuse_rt, s_rt, f_rt);
    check({tag, ".stall"}, 32'(stall), 32'(model_stall()));
    check({tag, ".fwd_rs"}, 32'(fwd_rs), 32'(f_rs));
    check({tag, ".fwd_rt"}, 32'(fwd_rt), 32'(f_rt));
  endtask

  // One clock edge with the reference advanced alongside, then outputs checked
  task automatic tick(input string tag);
    bit st;
    st = model_stall();
    if (mdu_start && !model_busy())
      busy_until = cyc + 1 + int'(mdu_is_div ? DIVC : MULTC);
    if (stat_clr) cnt_model = '0;
    else if (st && cnt_model != '1) cnt_model = cnt_model + 1;
    @(posedge clk);
    cyc++;
    #1;
    check({tag, ".busy"}, 32'(mdu_busy), 32'(model_busy()));
`ifdef STALL_PERF_CNT_EN
    check({tag, ".cnt"}, stall_cnt, cnt_model);
`endif
  endtask

  task automatic clear_regs();
    d_rs = 5'd0; d_rt = 5'd0;
    tuse_rs = '1; tuse_rt = '1;
    for (int k = 0; k < NS; k++) begin
      waddr_a[k] = 5'd0;
      tnew_a[k]  = '0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    d_is_mdu = 1'b0; mdu_start = 1'b0; mdu_is_div = 1'b0; stat_clr = 1'b0;
    clear_regs();
    #2;
    check("reset.busy", 32'(mdu_busy), 32'd0);
    check("reset.stall", 32'(stall), 32'd0);
    check("reset.fwd_rs", 32'(fwd_rs), 32'd0);
`ifdef STALL_PERF_CNT_EN
    check("reset.cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick("idle");

    // Rs late producer in E stalls; ready producer forwards from E
    d_rs = 5'd8; tuse_rs = 4'd0; waddr_a[0] = 5'd8; tnew_a[0] = 4'd1;
    check_comb("rs_late");
    check("rs_late.stall_const", 32'(stall), 32'd1);
    tnew_a[0] = 4'd0;
    check_comb("rs_ready");
    check("rs_ready.stall_const", 32'(stall), 32'd0);
    check("rs_ready.fwd_const", 32'(fwd_rs), 32'd1);

    // $0 never matches
    clear_regs();
    d_rt = 5'd0; tuse_rt = 4'd0; waddr_a[0] = 5'd0; tnew_a[0] = 4'd2;
    check_comb("r0");
    check("r0.stall_const", 32'(stall), 32'd0);
    check("r0.fwd_const", 32'(fwd_rt), 32'd0);

    // Younger not-ready match blocks a ready older copy
    clear_regs();
    d_rs = 5'd5; tuse_rs = 4'd1;
    waddr_a[0] = 5'd5; tnew_a[0] = 4'd1;
    waddr_a[1] = 5'd9; tnew_a[1] = 4'd3;
    waddr_a[2] = 5'd5; tnew_a[2] = 4'd0;
    check_comb("shadow");
    check("shadow.stall_const", 32'(stall), 32'd0);
    check("shadow.fwd_const", 32'(fwd_rs), 32'd0);
    tnew_a[0] = 4'd0; waddr_a[2] = 5'd0;
    check_comb("e_only");
    check("e_only.fwd_const", 32'(fwd_rs), 32'd1);
    clear_regs();
    d_rs = 5'd7; waddr_a[1] = 5'd7; d_rt = 5'd3; waddr_a[2] = 5'd3; tuse_rt = 4'd0;
    check_comb("m_w");
    check("m_w.fwd_rs_const", 32'(fwd_rs), 32'd2);
    check("m_w.fwd_rt_const", 32'(fwd_rt), 32'd3);

    // Div start: MDU instruction stalled in the start cycle and for DIVC cycles after
    clear_regs();
    d_is_mdu = 1'b1; mdu_start = 1'b1; mdu_is_div = 1'b1;
    check_comb("div_start");
    check("div_start.stall_const", 32'(stall), 32'd1);
    check("div_start.busy_const", 32'(mdu_busy), 32'd0);
    tick("div_start");
    mdu_start = 1'b0;
    for (int j = 0; j <= int'(DIVC); j++) begin
      check_comb($sformatf("div_%0d", j));
      check($sformatf("div_%0d.stall_const", j), 32'(stall), 32'(j < int'(DIVC)));
      tick($sformatf("div_%0d", j));
    end

    // Mult interrupted by reset: busy drops at once, no stall afterwards
    d_is_mdu = 1'b0; mdu_start = 1'b1; mdu_is_div = 1'b0;
    tick("mult_start");
    mdu_start = 1'b0;
    tick("mult_1");
    tick("mult_2");
    rst_n = 1'b0;
    busy_until = 0; cnt_model = '0;
    #1;
    check("mult_rst.busy", 32'(mdu_busy), 32'd0);
    #1;
    rst_n = 1'b1;
    d_is_mdu = 1'b1;
    check_comb("after_rst");
    check("after_rst.stall_const", 32'(stall), 32'd0);
    tick("after_rst");
    d_is_mdu = 1'b0;

`ifdef STALL_PERF_CNT_EN
    // Seven stall cycles counted; clear beats a concurrent stall
    stat_clr = 1'b1;
    tick("perf_clr");
    stat_clr = 1'b0;
    d_rs = 5'd8; tuse_rs = 4'd0; waddr_a[0] = 5'd8; tnew_a[0] = 4'd1;
    for (int j = 0; j < 7; j++) tick("perf_run");
    check("perf7.cnt_const", stall_cnt, 32'd7);
    stat_clr = 1'b1;
    tick("perf_clr_stall");
    check("perf_clr_stall.cnt_const", stall_cnt, 32'd0);
    stat_clr = 1'b0;
    clear_regs();
`endif

    // Randomized traffic over a small register set to provoke matches
    for (int i = 0; i < 300; i++) begin
      d_rs = 5'($urandom_range(0, 3));
      d_rt = 5'($urandom_range(0, 3));
      tuse_rs = ($urandom_range(0, 4) == 0) ? '1 : TW'($urandom_range(0, 3));
      tuse_rt = ($urandom_range(0, 4) == 0) ? '1 : TW'($urandom_range(0, 3));
      for (int k = 0; k < NS; k++) begin
        waddr_a[k] = 5'($urandom_range(0, 3));
        tnew_a[k]  = TW'($urandom_range(0, 3));
      end
      d_is_mdu   = 1'($urandom_range(0, 1));
      mdu_start  = model_busy() ? 1'b0 : 1'($urandom_range(0, 5) == 0);
      mdu_is_div = 1'($urandom_range(0, 1));
      stat_clr   = 1'($urandom_range(0, 15) == 0);
      check_comb($sformatf("rnd_%0d", i));
      tick($sformatf("rnd_%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
